xkbd_fifo: RTL and testbench
============================

XKBD_FIFO -- requirements
Module: xkbd_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYC, default 20000, idle clk cycles allowed between PS/2 falling edges mid-frame.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert to clk is the integrator's job.
REQ-005 ps2_clk  input  1  PS/2 clock pin, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 data pin, asynchronous to clk.
REQ-007 sel  input  1  bus select for this peripheral, one clk cycle per access.
REQ-008 we  input  1  1 = write access, 0 = read access; meaningful only with sel=1.
REQ-009 data_in  input  2  write data; bit0 = clear frame_err, bit1 = clear overflow.
REQ-010 data_out  output  11  [7:0] FIFO head byte, [8] valid (FIFO not empty), [9] frame_err sticky, [10] overflow sticky.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a PS/2 falling edge is a synced 1->0 transition of ps2_clk; data sampled is the synced ps2_data on that same cycle.
REQ-012 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on falling edge with data=0 (start bit) -> DATA, bit count 0; with data=1 remain IDLE.
REQ-014 DATA: each falling edge shifts the bit into the shift register LSB-first; after the 8th bit -> PARITY.
REQ-015 PARITY: on falling edge store the bit -> STOP.
REQ-016 STOP: on falling edge -> IDLE; frame is good if stop=1 and XOR of 8 data bits and parity bit is 1 (odd parity).
REQ-017 Good frame SHALL push the byte into the FIFO on the cycle after the stop-bit edge; byte visible in data_out[7:0] with valid=1 one cycle later if FIFO was empty.
REQ-018 Bad frame (parity or stop error) SHALL be dropped and set frame_err.
REQ-019 In DATA/PARITY/STOP a counter SHALL count clk cycles since the last falling edge; reaching TIMEOUT_CYC returns FSM to IDLE, drops the partial frame, sets frame_err; counter reset on every edge and in IDLE.
REQ-020 data_out SHALL be combinational from current state: head byte when not empty, 8'h00 with valid=0 when empty; status bits always reflect sticky flags.
REQ-021 Read (sel=1, we=0) with FIFO not empty SHALL pop the head on that clock edge; read of empty FIFO changes nothing.
REQ-022 Write (sel=1, we=1) SHALL clear each flag whose data_in bit is 1; FIFO unaffected.
REQ-023 Push when full and no pop in same cycle SHALL drop the byte and set overflow; push and pop in same cycle SHALL both succeed, count unchanged, including when full.
REQ-024 Flag set and write-clear in same cycle: set wins.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; full/empty derived from an occupancy count of width log2(DEPTH)+1.

Reset
REQ-026 rst=0 SHALL immediately force FSM IDLE, bit count 0, timeout counter 0, pointers and count 0, both flags 0, synchronizer flops 1; data_out = 11'h000.
REQ-027 rst asserted mid-frame SHALL discard the partial frame; the next start bit after release begins a fresh frame.

Verification
REQ-028 Frame 0x1C, parity 0, stop 1 at ~12 kHz PS/2 clock -> data_out = 11'h11C; one read -> 11'h000.
REQ-029 Frame 0x1C with parity 1 -> FIFO stays empty, data_out = 11'h200; write data_in=2'b01 -> 11'h000.
REQ-030 Nine good frames 0x01..0x09, no reads -> head 0x01, data_out = 11'h501; eight reads return 0x01..0x08 in order, then valid=0.
REQ-031 Start bit plus 3 data bits, then ps2_clk held high > TIMEOUT_CYC cycles -> FSM IDLE, frame_err=1; following good frame 0xF0 -> data_out = 11'h3F0.
REQ-032 FIFO full, read asserted on the exact push cycle of byte 0xAA -> no overflow, count stays 8, 0xAA is the last entry.
REQ-033 rst pulsed low during the DATA state of a frame, full FIFO with both flags set -> data_out = 11'h000 immediately; next good frame 0x5A -> 11'h15A.

Source files
------------

// File: rtl/xkbd_fifo.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver with a byte FIFO and a tiny register interface.
// Ports:
//   clk, rst        system clock and async active-low reset
//   ps2_clk/data    raw PS/2 pins, asynchronous to clk
//   sel, we         one-cycle bus access strobe and direction
//   data_in[1:0]    write: bit0 clears frame_err, bit1 clears overflow
//   data_out[10:0]  {overflow, frame_err, valid, head byte}, combinational
module xkbd_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  data_in,
    output logic [10:0] data_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    push_byte_q, push_byte_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic fall;
    logic ferr_set;
    logic ovf_set;
    logic do_pop;
    logic do_push;
    logic not_empty;

    // Synchronizers and previous synced ps2_clk for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Receiver next-state logic including the mid-frame idle timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        ferr_set    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                if (fall && !dat_s2_q) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    // Odd parity over data plus parity bit, stop must be high.
                    if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                tmo_d     = '0;
                ferr_set  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // FIFO pointer/count and sticky flag next-state logic.
    always_comb begin
        not_empty = (count_q != '0);
        do_pop    = sel & ~we & not_empty;
        do_push   = push_q & ((count_q != CW'(DEPTH)) | do_pop);
        ovf_set   = push_q & (count_q == CW'(DEPTH)) & ~do_pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end

        // Set has priority over a same-cycle clear.
        ferr_d = ferr_q;
        ovf_d  = ovf_q;
        if (sel && we && data_in[0]) begin
            ferr_d = 1'b0;
        end
        if (sel && we && data_in[1]) begin
            ovf_d = 1'b0;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents are masked by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_byte_q;
        end
    end

    assign data_out = {ovf_q, ferr_q, (count_q != '0),
                       (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00};

endmodule

// File: tb/tb_xkbd_fifo.sv
`timescale 1ns/1ps
// Bench for xkbd_fifo: directed scenarios plus a randomized phase against a
// queue-based model of the receiver and FIFO.
module tb_xkbd_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HP    = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        sel;
    logic        we;
    logic [1:0]  data_in;
    logic [10:0] data_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         m_ferr;
    bit         m_ovf;

    always #5 clk = ~clk;

    xkbd_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] exp_out();
        logic [7:0] h;
        h = (q.size() != 0) ? q[0] : 8'h00;
        return {m_ovf, m_ferr, (q.size() != 0), h};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        vectors++;
        assert (data_out === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(b);
    endtask

    // One PS/2 bit; optionally issue a bus read on the cycle the FIFO push lands.
    task automatic ps2_edge(input logic b, input bit rd_at_push);
        @(negedge clk) ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        if (rd_at_push) begin
            repeat (3) @(negedge clk);
            sel = 1'b1; we = 1'b0;
            @(negedge clk);
            sel = 1'b0;
            repeat (HP - 4) @(negedge clk);
        end else begin
            repeat (HP) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (HP - 5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_err,
                              input bit stop_err, input bit rd_at_push);
        ps2_edge(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_edge(b[i], 1'b0);
        ps2_edge((~^b) ^ par_err, 1'b0);
        ps2_edge(~stop_err, rd_at_push);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        if (rd_at_push && q.size() != 0) void'(q.pop_front());
        if (par_err || stop_err) m_ferr = 1'b1;
        else model_push(b);
    endtask

    task automatic bus_read();
        @(negedge clk) begin sel = 1'b1; we = 1'b0; end
        @(negedge clk) sel = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic bus_write(input logic [1:0] d);
        @(negedge clk) begin sel = 1'b1; we = 1'b1; data_in = d; end
        @(negedge clk) begin sel = 1'b0; we = 1'b0; data_in = 2'b00; end
        if (d[0]) m_ferr = 1'b0;
        if (d[1]) m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         r;

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        sel = 1'b0; we = 1'b0; data_in = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset", 11'h000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Basic good frame and read.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("good_1c", 11'h11C);
        bus_read();
        @(negedge clk);
        check("read_1c", 11'h000);

        // Parity error and flag clear.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("par_err", 11'h200);
        bus_write(2'b01);
        @(negedge clk);
        check("clr_ferr", 11'h000);

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("ovf_head", 11'h501);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain", {3'b101, 8'(i)});
            bus_read();
        end
        @(negedge clk);
        check("drained", 11'h400);
        bus_write(2'b10);
        @(negedge clk);
        check("clr_ovf", exp_out());

        // Timeout after a partial frame.
        ps2_edge(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_edge(1'b1, 1'b0);
        repeat (TMO + 50) @(negedge clk);
        m_ferr = 1'b1;
        check("timeout", 11'h200);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check("after_tmo", 11'h3F0);
        bus_read();
        bus_write(2'b01);
        @(negedge clk);
        check("tmo_clean", 11'h000);

        // Full FIFO with a read on the exact push cycle.
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        check("push_pop_full", exp_out());
        for (int i = 0; i < DEPTH; i++) begin
            check("pp_drain", exp_out());
            rb = q[0];
            bus_read();
            if (i == DEPTH - 1) begin
                vectors++;
                assert (rb === 8'hAA) else begin
                    miscompares++;
                    $error("FAIL pp_last: observed %h expected aa", rb);
                end
            end
        end
        @(negedge clk);
        check("pp_empty", 11'h000);

        // Randomized mix of frames, reads and flag writes.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                r = int'($urandom_range(0, 5));
                send_frame(8'($urandom), (r == 0), (r == 1), 1'b0);
            end else if (r < 8) begin
                bus_read();
            end else begin
                bus_write(2'($urandom));
            end
            @(negedge clk);
            check("rand", exp_out());
        end

        // Full FIFO, both flags set, then reset mid-frame.
        while (q.size() < DEPTH) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0);
        check("pre_rst", exp_out());
        ps2_edge(1'b0, 1'b0);
        ps2_edge(1'b1, 1'b0);
        ps2_edge(1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        model_reset();
        check("rst_async", 11'h000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_release", 11'h000);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("after_rst", 11'h15A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
